// File: rtl/bias_weight_updater_pkg.sv
// +----------------------------------------------------------------------+
// | bias_weight_updater_pkg                                              |
// | Shared types, width helpers and packing offsets for the updater.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package bias_weight_updater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  function automatic int word_width(input int wi, input int wf);
    return wi + wf;
  endfunction

  function automatic int cnt_width(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

  function automatic int sat_max(input int wd);
    return (1 << (wd - 1)) - 1;
  endfunction

  function automatic int sat_min(input int wd);
    return -(1 << (wd - 1));
  endfunction

  // Bit offsets inside the packed parameter bus: weights first, then biases.
  function automatic int w_lsb(input int c, input int p, input int np, input int wd);
    return (c * np + p) * wd;
  endfunction

  function automatic int b_lsb(input int c, input int np, input int nc, input int wd);
    return (nc * np + c) * wd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bias_weight_updater_mul.sv
// +----------------------------------------------------------------------+
// | fxp_mul_sat                                                          |
// | Signed fixed-point multiply, arithmetic shift by WF, saturate to WD. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fxp_mul_sat #(
  parameter int WD = 8,
  parameter int WF = 4
) (
  input  logic [WD-1:0] i_a,
  input  logic [WD-1:0] i_b,
  output logic [WD-1:0] o_y
);

  logic signed [2*WD-1:0] w_prod;
  logic signed [2*WD-1:0] w_shift;
  logic                   w_in_range;

  always_comb begin
    w_prod     = $signed({{WD{i_a[WD-1]}}, i_a}) * $signed({{WD{i_b[WD-1]}}, i_b});
    w_shift    = w_prod >>> WF;
    // Fits in WD bits only when every bit above the result sign agrees with it.
    w_in_range = (&w_shift[2*WD-1:WD-1]) | ~(|w_shift[2*WD-1:WD-1]);
    if (w_in_range) begin
      o_y = w_shift[WD-1:0];
    end else if (w_shift[2*WD-1]) begin
      o_y = {1'b1, {(WD-1){1'b0}}};
    end else begin
      o_y = {1'b0, {(WD-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/bias_weight_updater.sv
// +----------------------------------------------------------------------+
// | bias_weight_updater                                                  |
// | Layer parameter store with saturating SGD update and stream output.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bias_weight_updater
  import bias_weight_updater_pkg::*;
#(
  parameter  int NP = 4,
  parameter  int NC = 4,
  parameter  int WI = 4,
  parameter  int WF = 4,
  localparam int WD = word_width(WI, WF)
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iMode,
  input  logic [WD-1:0]             iLR,
  input  logic                      iValid_AS,
  output logic                      oReady_AS,
  input  logic [NP*WD+NC*WD-1:0]    iData_AS,
  input  logic                      iValid_LD,
  output logic                      oReady_LD,
  input  logic [NC*NP*WD+NC*WD-1:0] iData_LD,
  output logic                      oValid_BS,
  input  logic                      iReady_BS,
  output logic [NC*NP*WD+NC*WD-1:0] oData_BS
);

  localparam int CW = cnt_width(NC);
  localparam int PW = NC*NP*WD + NC*WD;
  localparam int AW = NP*WD + NC*WD;
  localparam logic [WD-1:0] SAT_MAX = WD'(sat_max(WD));
  localparam logic [WD-1:0] SAT_MIN = WD'(sat_min(WD));

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [PW-1:0]  r_params, w_params_nxt;
  logic [NP*WD-1:0] r_x;
  logic [NC*WD-1:0] r_d;
  logic [WD-1:0]  r_lr;

  logic [WD-1:0]  w_d_cur;
  logic [WD-1:0]  w_g;
  logic [WD-1:0]  w_x  [NP];
  logic [WD-1:0]  w_gx [NP];
  logic           w_accept;
  logic           w_last;
  int             w_c;

  function automatic logic [WD-1:0] sat_sub(input logic [WD-1:0] a, input logic [WD-1:0] b);
    logic [WD:0] diff;
    diff = {a[WD-1], a} - {b[WD-1], b};
    if (diff[WD] != diff[WD-1]) begin
      return diff[WD] ? SAT_MIN : SAT_MAX;
    end
    return diff[WD-1:0];
  endfunction

  assign w_accept = (r_state == ST_IDLE) && iMode && iValid_AS && !iValid_LD;
  assign w_last   = (r_cnt == CW'(NC - 1));
  assign w_c      = int'(r_cnt);
  assign w_d_cur  = r_d[w_c*WD +: WD];
  assign oData_BS = r_params;

  fxp_mul_sat #(.WD(WD), .WF(WF)) u_grad (
    .i_a (r_lr),
    .i_b (w_d_cur),
    .o_y (w_g)
  );

  generate
    for (genvar p = 0; p < NP; p++) begin : g_prod
      assign w_x[p] = r_x[p*WD +: WD];
      fxp_mul_sat #(.WD(WD), .WF(WF)) u_gx (
        .i_a (w_g),
        .i_b (w_x[p]),
        .o_y (w_gx[p])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_params_nxt = r_params;
    oReady_AS    = 1'b0;
    oReady_LD    = 1'b0;
    oValid_BS    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        oReady_LD = 1'b1;
        oReady_AS = iMode && !iValid_LD;
        oValid_BS = !iMode && !iValid_LD;
        if (iValid_LD) begin
          w_params_nxt = iData_LD;
        end else if (w_accept) begin
          w_state_nxt = ST_UPDATE;
          w_cnt_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        w_params_nxt[b_lsb(w_c, NP, NC, WD) +: WD] =
          sat_sub(r_params[b_lsb(w_c, NP, NC, WD) +: WD], w_g);
        for (int p = 0; p < NP; p++) begin
          w_params_nxt[w_lsb(w_c, p, NP, WD) +: WD] =
            sat_sub(r_params[w_lsb(w_c, p, NP, WD) +: WD], w_gx[p]);
        end
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PUBLISH;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_PUBLISH: begin
        oValid_BS = 1'b1;
        if (iReady_BS) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_params <= '0;
      r_x      <= '0;
      r_d      <= '0;
      r_lr     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_params <= w_params_nxt;
      if (w_accept) begin
        r_x  <= iData_AS[NP*WD-1:0];
        r_d  <= iData_AS[AW-1:NP*WD];
        r_lr <= iLR;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bias_weight_updater.sv
// +----------------------------------------------------------------------+
// | tb_bias_weight_updater                                               |
// | Scoreboard bench with an arithmetic reference model of the update.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bias_weight_updater;

  localparam int NP = 2;
  localparam int NC = 2;
  localparam int WI = 4;
  localparam int WF = 4;
  localparam int WD = WI + WF;
  localparam int PW = NC*NP*WD + NC*WD;
  localparam int AW = NP*WD + NC*WD;

  logic          clk = 1'b0;
  logic          iRST = 1'b0;
  logic          iMode = 1'b0;
  logic [WD-1:0] iLR = '0;
  logic          iValid_AS = 1'b0;
  logic          oReady_AS;
  logic [AW-1:0] iData_AS = '0;
  logic          iValid_LD = 1'b0;
  logic          oReady_LD;
  logic [PW-1:0] iData_LD = '0;
  logic          oValid_BS;
  logic          iReady_BS = 1'b0;
  logic [PW-1:0] oData_BS;

  typedef struct {
    logic [PW-1:0] data;
    int            rise;
  } exp_t;

  exp_t sb_q[$];
  int   m_w [NC][NP];
  int   m_b [NC];
  int   m_x [NP];
  int   m_d [NC];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  bit   prev_valid = 1'b0;

  bias_weight_updater #(.NP(NP), .NC(NC), .WI(WI), .WF(WF)) dut (
    .iCLK      (clk),
    .iRST      (iRST),
    .iMode     (iMode),
    .iLR       (iLR),
    .iValid_AS (iValid_AS),
    .oReady_AS (oReady_AS),
    .iData_AS  (iData_AS),
    .iValid_LD (iValid_LD),
    .oReady_LD (oReady_LD),
    .iData_LD  (iData_LD),
    .oValid_BS (oValid_BS),
    .iReady_BS (iReady_BS),
    .oData_BS  (oData_BS)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Mathematical floor of v / 2^WF.
  function automatic int fdiv(input int v);
    if (v >= 0) return v / (1 << WF);
    return -((-v + (1 << WF) - 1) / (1 << WF));
  endfunction

  function automatic int rnd_word();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic logic [PW-1:0] pack_params();
    logic [PW-1:0] v = '0;
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < NP; p++) v[(c*NP+p)*WD +: WD] = WD'(m_w[c][p]);
      v[NC*NP*WD + c*WD +: WD] = WD'(m_b[c]);
    end
    return v;
  endfunction

  function automatic logic [AW-1:0] pack_as();
    logic [AW-1:0] v = '0;
    for (int p = 0; p < NP; p++) v[p*WD +: WD] = WD'(m_x[p]);
    for (int c = 0; c < NC; c++) v[NP*WD + c*WD +: WD] = WD'(m_d[c]);
    return v;
  endfunction

  task automatic model_train(input int lr);
    int g;
    for (int c = 0; c < NC; c++) begin
      g = sat(fdiv(lr * m_d[c]));
      m_b[c] = sat(m_b[c] - g);
      for (int p = 0; p < NP; p++) m_w[c][p] = sat(m_w[c][p] - sat(fdiv(g * m_x[p])));
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_b[c] = 0;
      for (int p = 0; p < NP; p++) m_w[c][p] = 0;
    end
  endtask

  task automatic model_rand_params();
    for (int c = 0; c < NC; c++) begin
      m_b[c] = rnd_word();
      for (int p = 0; p < NP; p++) m_w[c][p] = rnd_word();
    end
  endtask

  task automatic rand_beat();
    for (int p = 0; p < NP; p++) m_x[p] = rnd_word();
    for (int c = 0; c < NC; c++) m_d[c] = rnd_word();
  endtask

  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (iRST) begin
      if (oValid_BS && !prev_valid) rise_cyc = cyc;
      if (oValid_BS && iReady_BS) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_handshake: got data %h expected no transfer", oData_BS);
        end else begin
          e = sb_q.pop_front();
          check_vec("publish_data", oData_BS, e.data);
          if (e.rise >= 0) check("valid_latency", rise_cyc, e.rise);
        end
      end
    end
    prev_valid = iRST && oValid_BS;
  end

  task automatic load(input bit with_beat);
    @(posedge clk); #1;
    iValid_LD = 1'b1;
    iData_LD  = pack_params();
    if (with_beat) begin
      iMode     = 1'b1;
      iData_AS  = pack_as();
      iValid_AS = 1'b1;
    end
    @(negedge clk);
    check("load_ready_ld", oReady_LD, 1);
    check("load_valid_bs", oValid_BS, 0);
    check("load_ready_as", oReady_AS, 0);
    @(posedge clk); #1;
    iValid_LD = 1'b0;
    iValid_AS = 1'b0;
    if (with_beat) begin
      @(negedge clk);
      check("load_wins_still_idle", oReady_AS, 1);
      check_vec("load_data", oData_BS, pack_params());
    end
  endtask

  task automatic infer();
    exp_t e;
    @(posedge clk); #1;
    iMode     = 1'b0;
    iReady_BS = 1'b1;
    e.data = pack_params();
    e.rise = -1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    iReady_BS = 1'b0;
  endtask

  task automatic train(input int lr, input int hold, input bit rst_mid);
    exp_t e;
    int   n;
    int   acc;
    @(posedge clk); #1;
    iMode     = 1'b1;
    iLR       = WD'(lr);
    iData_AS  = pack_as();
    iValid_AS = 1'b1;
    iReady_BS = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oReady_AS && n < 50);
    if (!oReady_AS) begin
      check("accept_timeout", 0, 1);
      iValid_AS = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    iValid_AS = 1'b0;
    if (rst_mid) begin
      iRST = 1'b0;
      @(posedge clk); #1;
      iRST = 1'b1;
      model_clear();
      @(negedge clk);
      check_vec("reset_mid_update_params", oData_BS, '0);
      check("reset_mid_update_idle", oReady_LD, 1);
      return;
    end
    model_train(lr);
    e.data = pack_params();
    e.rise = acc + NC;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oValid_BS && n < 50);
    if (!oValid_BS) begin
      check("publish_timeout", 0, 1);
      return;
    end
    if (hold > 0) iValid_AS = 1'b1;
    for (int k = 0; k < hold; k++) begin
      check("hold_ready_as", oReady_AS, 0);
      check("hold_valid_bs", oValid_BS, 1);
      check_vec("hold_data", oData_BS, pack_params());
      @(negedge clk);
    end
    @(posedge clk); #1;
    iReady_BS = 1'b1;
    @(posedge clk); #1;
    iReady_BS = 1'b0;
    iValid_AS = 1'b0;
  endtask

  initial begin
    model_clear();
    for (int p = 0; p < NP; p++) m_x[p] = 0;
    for (int c = 0; c < NC; c++) m_d[c] = 0;
    repeat (2) @(posedge clk);
    #1 iRST = 1'b1;
    @(negedge clk);
    check("reset_valid_bs", oValid_BS, 1);
    check_vec("reset_data", oData_BS, '0);
    check("reset_ready_as", oReady_AS, 0);
    check("reset_ready_ld", oReady_LD, 1);
    infer();

    // Basic update: child 0 moves, child 1 has zero delta.
    model_clear(); load(1'b0);
    m_x = '{32, 16}; m_d = '{16, 0};
    train(8, 0, 1'b0);

    // Floor rounding of a tiny negative gradient.
    model_clear(); load(1'b0);
    m_x = '{16, 0}; m_d = '{-1, 0};
    train(1, 0, 1'b0);

    // Saturation at the negative rail.
    model_clear(); m_w[0][0] = -128; m_b[0] = -120; load(1'b0);
    m_x = '{112, 0}; m_d = '{112, 0};
    train(16, 0, 1'b0);
    infer();

    // Backpressure then a follow-on beat.
    rand_beat(); train(rnd_word(), 5, 1'b0);
    rand_beat(); train(rnd_word(), 0, 1'b0);

    // Load and beat together: load wins.
    model_rand_params(); rand_beat(); load(1'b1);
    infer();

    // Reset in the middle of UPDATE.
    rand_beat(); train(rnd_word(), 0, 1'b1);
    infer();

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin model_rand_params(); load(1'b0); end
        1: infer();
        default: begin rand_beat(); train(rnd_word(), int'($urandom_range(0, 3)), 1'b0); end
      endcase
    end
    infer();

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
